// File: rtl/regfile_write_ctrl_pkg.sv
// Shared definitions for the register-file write side and its read-port mux.
package regfile_write_ctrl_pkg;

    localparam int unsigned WIDTH_DEF     = 16;
    localparam int unsigned NREGS_DEF     = 8;
    localparam int unsigned AW_DEF        = $clog2(NREGS_DEF);
    // Address 0 selects external data on the read side and holds no storage.
    localparam int unsigned REG_ZERO_ADDR = 0;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/regfile_store.sv
// Storage flops for R1..R(NREGS-1) with per-register dirty bits and one write port.
module regfile_store
    import regfile_write_ctrl_pkg::*;
#(
    parameter int unsigned     WIDTH     = WIDTH_DEF,
    parameter int unsigned     NREGS     = NREGS_DEF,
    parameter int unsigned     AW        = AW_DEF,
    parameter logic [WIDTH-1:0] CLR_VALUE = '0
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_we,
    input  logic [AW-1:0]                i_waddr,
    input  logic [WIDTH-1:0]             i_wdata,
    input  logic                         i_wdirty,
    output logic [NREGS-2:0]             o_dirty,
    output logic [(NREGS-1)*WIDTH-1:0]   o_regs_flat
);

    localparam int unsigned NSTORE = NREGS - 1;

    logic [WIDTH-1:0]  r_regs [NSTORE];
    logic [NSTORE-1:0] r_dirty;

    // Storage index i holds register R(i+1); address 0 never matches.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < int'(NSTORE); i++) begin
                r_regs[i] <= CLR_VALUE;
            end
            r_dirty <= '0;
        end else if (i_we) begin
            for (int i = 0; i < int'(NSTORE); i++) begin
                if (i_waddr == AW'(i + 1)) begin
                    r_regs[i]  <= i_wdata;
                    r_dirty[i] <= i_wdirty;
                end
            end
        end
    end

    for (genvar g = 0; g < int'(NSTORE); g++) begin : g_flat
        assign o_regs_flat[g*WIDTH +: WIDTH] = r_regs[g];
    end

    assign o_dirty = r_dirty;

endmodule

// File: rtl/regfile_write_ctrl.sv
// Register-file write side: write handshake, sequenced clear, address-0 error flag.
module regfile_write_ctrl
    import regfile_write_ctrl_pkg::*;
#(
    parameter int unsigned      WIDTH     = WIDTH_DEF,
    parameter int unsigned      NREGS     = NREGS_DEF,
    parameter int unsigned      AW        = AW_DEF,
    parameter logic [WIDTH-1:0] CLR_VALUE = '0
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_wr_valid,
    output logic                         o_wr_ready,
    input  logic [AW-1:0]                i_wr_addr,
    input  logic [WIDTH-1:0]             i_wr_data,
    input  logic                         i_clr_req,
    output logic                         o_busy,
    output logic                         o_wr_err,
    output logic [NREGS-2:0]             o_dirty,
    output logic [(NREGS-1)*WIDTH-1:0]   o_regs_flat
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(NREGS - 1);
    localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO_ADDR);

    state_t          r_state;
    state_t          w_next_state;
    logic [AW-1:0]   r_idx;
    logic [AW-1:0]   w_next_idx;
    logic            r_busy;
    logic            r_wr_err;
    logic            w_wr_err;
    logic            w_wr_ready;
    logic            w_we;
    logic [AW-1:0]   w_waddr;
    logic [WIDTH-1:0] w_wdata;
    logic            w_wdirty;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_idx    <= AW'(1);
            r_busy   <= 1'b0;
            r_wr_err <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_idx    <= w_next_idx;
            r_busy   <= (w_next_state == ST_CLEAR);
            r_wr_err <= w_wr_err;
        end
    end

    // Clear has priority over a write presented in the same IDLE cycle.
    always_comb begin
        w_next_state = r_state;
        w_next_idx   = r_idx;
        w_wr_ready   = 1'b0;
        w_wr_err     = 1'b0;
        w_we         = 1'b0;
        w_waddr      = i_wr_addr;
        w_wdata      = i_wr_data;
        w_wdirty     = 1'b1;
        unique case (r_state)
            ST_IDLE: begin
                w_wr_ready = !i_clr_req;
                if (i_clr_req) begin
                    w_next_state = ST_CLEAR;
                    w_next_idx   = AW'(1);
                end else if (i_wr_valid) begin
                    if (i_wr_addr == ZERO_ADDR) begin
                        w_wr_err = 1'b1;
                    end else begin
                        w_we = 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                w_we     = 1'b1;
                w_waddr  = r_idx;
                w_wdata  = CLR_VALUE;
                w_wdirty = 1'b0;
                if (r_idx == LAST_ADDR) begin
                    w_next_state = ST_IDLE;
                    w_next_idx   = AW'(1);
                end else begin
                    w_next_idx   = r_idx + AW'(1);
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_next_idx   = AW'(1);
            end
        endcase
    end

    regfile_store #(
        .WIDTH     (WIDTH),
        .NREGS     (NREGS),
        .AW        (AW),
        .CLR_VALUE (CLR_VALUE)
    ) u_store (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_we        (w_we),
        .i_waddr     (w_waddr),
        .i_wdata     (w_wdata),
        .i_wdirty    (w_wdirty),
        .o_dirty     (o_dirty),
        .o_regs_flat (o_regs_flat)
    );

    assign o_wr_ready = w_wr_ready;
    assign o_busy     = r_busy;
    assign o_wr_err   = r_wr_err;

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Scoreboard bench for regfile_write_ctrl: a behavioural model predicts each cycle.
module tb_regfile_write_ctrl;

    logic         clk;
    logic         rst;
    logic         wr_valid;
    logic         wr_ready;
    logic [2:0]   wr_addr;
    logic [15:0]  wr_data;
    logic         clr_req;
    logic         busy;
    logic         wr_err;
    logic [6:0]   dirty;
    logic [111:0] regs_flat;

    regfile_write_ctrl dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_wr_valid  (wr_valid),
        .o_wr_ready  (wr_ready),
        .i_wr_addr   (wr_addr),
        .i_wr_data   (wr_data),
        .i_clr_req   (clr_req),
        .o_busy      (busy),
        .o_wr_err    (wr_err),
        .o_dirty     (dirty),
        .o_regs_flat (regs_flat)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [111:0] flat;
        logic [6:0]   dirty;
        logic         busy;
        logic         err;
    } exp_t;

    exp_t        q[$];
    int          n_vec = 0;
    int          n_bad = 0;

    logic [15:0] m_regs [1:7];
    logic [6:0]  m_dirty;
    logic        m_clear;
    logic [2:0]  m_idx;
    logic        m_err;

    function automatic logic [111:0] m_flat();
        logic [111:0] f;
        for (int i = 1; i <= 7; i++) f[(i-1)*16 +: 16] = m_regs[i];
        return f;
    endfunction

    task automatic model_edge();
        if (rst) begin
            for (int i = 1; i <= 7; i++) m_regs[i] = 16'h0;
            m_dirty = 7'h0; m_clear = 1'b0; m_idx = 3'd1; m_err = 1'b0;
        end else begin
            m_err = 1'b0;
            if (!m_clear) begin
                if (clr_req) begin
                    m_clear = 1'b1; m_idx = 3'd1;
                end else if (wr_valid) begin
                    if (wr_addr == 3'd0) m_err = 1'b1;
                    else begin
                        m_regs[wr_addr] = wr_data;
                        m_dirty[wr_addr-1] = 1'b1;
                    end
                end
            end else begin
                m_regs[m_idx] = 16'h0;
                m_dirty[m_idx-1] = 1'b0;
                if (m_idx == 3'd7) m_clear = 1'b0;
                else m_idx = m_idx + 3'd1;
            end
        end
    endtask

    // One clock: check ready before the edge, push the prediction, pop and compare after.
    task automatic cycle(output logic acc);
        logic pre_ready;
        exp_t e;
        exp_t got;
        #1;
        pre_ready = !m_clear && !clr_req;
        acc = wr_valid && pre_ready && !rst;
        if (!rst) begin
            n_vec++;
            if (wr_ready !== pre_ready) begin
                n_bad++;
                $display("FAIL wr_ready got %b want %b at %0t", wr_ready, pre_ready, $time);
            end
        end
        @(posedge clk);
        model_edge();
        e.flat = m_flat(); e.dirty = m_dirty; e.busy = m_clear; e.err = m_err;
        q.push_back(e);
        @(negedge clk);
        e = q.pop_front();
        got.flat = regs_flat; got.dirty = dirty; got.busy = busy; got.err = wr_err;
        n_vec++;
        if (got.flat !== e.flat) begin
            n_bad++; $display("FAIL regs_flat got %h want %h at %0t", got.flat, e.flat, $time);
        end
        n_vec++;
        if (got.dirty !== e.dirty) begin
            n_bad++; $display("FAIL dirty got %h want %h at %0t", got.dirty, e.dirty, $time);
        end
        n_vec++;
        if (got.busy !== e.busy) begin
            n_bad++; $display("FAIL busy got %b want %b at %0t", got.busy, e.busy, $time);
        end
        n_vec++;
        if (got.err !== e.err) begin
            n_bad++; $display("FAIL wr_err got %b want %b at %0t", got.err, e.err, $time);
        end
    endtask

    task automatic do_write(input logic [2:0] a, input logic [15:0] d);
        logic acc;
        acc = 1'b0;
        wr_valid = 1'b1; wr_addr = a; wr_data = d;
        for (int k = 0; k < 40 && !acc; k++) cycle(acc);
        n_vec++;
        if (!acc) begin
            n_bad++; $display("FAIL write_timeout addr %0d got no accept want accept", a);
        end
        wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic acc;
        rst = 1'b1;
        cycle(acc);
        cycle(acc);
        rst = 1'b0;
        #1;
        n_vec++;
        if (regs_flat !== 112'h0 || dirty !== 7'h00 || busy !== 1'b0 || wr_err !== 1'b0 || wr_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_state got flat=%h dirty=%h busy=%b err=%b rdy=%b want all 0, rdy 1",
                     regs_flat, dirty, busy, wr_err, wr_ready);
        end
        cycle(acc);
    endtask

    task automatic test_write();
        logic [111:0] want;
        want = 112'h0;
        want[47:32] = 16'hBEEF;
        do_write(3'd3, 16'hBEEF);
        n_vec++;
        if (regs_flat !== want || dirty !== 7'h04) begin
            n_bad++;
            $display("FAIL write_r3 got flat=%h dirty=%h want flat=%h dirty=04", regs_flat, dirty, want);
        end
    endtask

    task automatic test_back_to_back();
        do_write(3'd6, 16'hAAAA);
        do_write(3'd6, 16'h5555);
        n_vec++;
        if (regs_flat[95:80] !== 16'h5555 || dirty !== 7'h24) begin
            n_bad++;
            $display("FAIL back_to_back got r6=%h dirty=%h want 5555 24", regs_flat[95:80], dirty);
        end
    endtask

    task automatic test_clear();
        logic acc;
        int   nbusy;
        for (int i = 1; i <= 7; i++) do_write(3'(i), 16'(i));
        clr_req = 1'b1;
        cycle(acc);
        clr_req = 1'b0;
        nbusy = int'(busy);
        for (int i = 0; i < 7; i++) begin
            cycle(acc);
            nbusy += int'(busy);
        end
        n_vec++;
        if (nbusy != 7 || regs_flat !== 112'h0 || dirty !== 7'h00) begin
            n_bad++;
            $display("FAIL clear_seq got busy_cycles=%0d flat=%h dirty=%h want 7 0 0", nbusy, regs_flat, dirty);
        end
    endtask

    task automatic test_clr_vs_write();
        logic acc;
        int   waits;
        clr_req = 1'b1; wr_valid = 1'b1; wr_addr = 3'd5; wr_data = 16'h1234;
        cycle(acc);
        n_vec++;
        if (acc !== 1'b0) begin
            n_bad++; $display("FAIL collide_accept got %b want 0", acc);
        end
        clr_req = 1'b0;
        waits = 0;
        acc = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) begin
            cycle(acc);
            waits++;
        end
        wr_valid = 1'b0;
        n_vec++;
        if (waits != 8 || regs_flat[79:64] !== 16'h1234 || dirty !== 7'h10) begin
            n_bad++;
            $display("FAIL collide_write got waits=%0d r5=%h dirty=%h want 8 1234 10",
                     waits, regs_flat[79:64], dirty);
        end
    endtask

    task automatic test_addr0();
        logic         acc;
        logic [111:0] flat_before;
        logic [6:0]   dirty_before;
        flat_before  = m_flat();
        dirty_before = m_dirty;
        do_write(3'd0, 16'hFFFF);
        n_vec++;
        if (wr_err !== 1'b1 || regs_flat !== flat_before || dirty !== dirty_before) begin
            n_bad++;
            $display("FAIL addr0_err got err=%b flat=%h dirty=%h want 1 %h %h",
                     wr_err, regs_flat, dirty, flat_before, dirty_before);
        end
        cycle(acc);
        n_vec++;
        if (wr_err !== 1'b0) begin
            n_bad++; $display("FAIL addr0_pulse got err=%b want 0", wr_err);
        end
    endtask

    task automatic test_reset_mid_clear();
        logic acc;
        for (int i = 1; i <= 7; i++) do_write(3'(i), 16'hA000 | 16'(i));
        clr_req = 1'b1;
        cycle(acc);
        clr_req = 1'b0;
        cycle(acc);
        cycle(acc);
        rst = 1'b1;
        cycle(acc);
        rst = 1'b0;
        #1;
        n_vec++;
        if (regs_flat !== 112'h0 || busy !== 1'b0 || wr_ready !== 1'b1 || dirty !== 7'h00) begin
            n_bad++;
            $display("FAIL reset_mid_clear got flat=%h busy=%b rdy=%b dirty=%h want 0 0 1 0",
                     regs_flat, busy, wr_ready, dirty);
        end
        cycle(acc);
    endtask

    initial begin
        rst = 1'b1; wr_valid = 1'b0; wr_addr = 3'd0; wr_data = 16'h0; clr_req = 1'b0;
        for (int i = 1; i <= 7; i++) m_regs[i] = 16'h0;
        m_dirty = 7'h0; m_clear = 1'b0; m_idx = 3'd1; m_err = 1'b0;
        @(negedge clk);
        test_reset();
        test_write();
        test_back_to_back();
        test_clear();
        test_clr_vs_write();
        test_addr0();
        test_reset_mid_clear();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
